pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards:
- load-use, by inserting a bubble;
- taken branch, by squashing IF/ID;
- data-cache miss, by freezing the front of the pipeline and running a request/ack handshake with the memory.

The block sits beside the hazard detection path in ID and the data cache in MEM.

---
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush controller for the 5-stage pipeline (load-use,
//            taken branch, data-cache miss refill handshake).
//            Optional performance counters: define PIPE_CTRL_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dcache_hit_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             dcache_fill_o,
    output logic             pc_we_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] miss_count_o,
`endif
    output logic             memwb_flush_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipeline_hazard_ctrl: CNT_W must be at least 1");
    end

    state_t state_q, state_d;
    logic   mem_req_q, mem_req_d;
    logic   dcache_fill_q, dcache_fill_d;

    logic w_miss_start;
    logic w_miss;
    logic w_lu;

    assign w_miss_start = (state_q == ST_RUN) && dmem_req_i && !dcache_hit_i;
    assign w_miss       = w_miss_start || (state_q == ST_MISS) || (state_q == ST_FILL);
    assign w_lu         = idex_memread_i && (idex_rt_i != 5'd0) &&
                          ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // Refill handshake; ack is only honoured while the request is visible.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = 1'b0;
        dcache_fill_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_miss_start) begin
                    state_d   = ST_MISS;
                    mem_req_d = 1'b1;
                end
            end
            ST_MISS: begin
                if (mem_ack_i) begin
                    state_d       = ST_FILL;
                    dcache_fill_d = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_FILL: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            mem_req_q     <= 1'b0;
            dcache_fill_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            dcache_fill_q <= dcache_fill_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign dcache_fill_o = dcache_fill_q;

    // A miss freezes everything up to EX/MEM and pushes a bubble into WB.
    always_comb begin
        pc_we_o       = 1'b1;
        ifid_en_o     = 1'b1;
        idex_en_o     = 1'b1;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        memwb_flush_o = 1'b0;
        if (rst_i) begin
            pc_we_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_en_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            memwb_flush_o = 1'b1;
        end else if (w_miss) begin
            pc_we_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_flush_o = 1'b1;
        end else if (w_lu) begin
            pc_we_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        miss_count_d   = miss_count_q;
        if (!pc_we_o && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (w_miss_start && (miss_count_q != {CNT_W{1'b1}})) begin
            miss_count_d = miss_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign miss_count_o   = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed plus randomized self-checking bench for
//            pipeline_hazard_ctrl against a protocol-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       idex_memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       branch_taken, dmem_req, dcache_hit, mem_ack;
    logic       mem_req, dcache_fill;
    logic       pc_we, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_flush;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, miss_count;
`endif

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clock_i        (clk),
        .rst_i          (rst),
        .idex_memread_i (idex_memread),
        .idex_rt_i      (idex_rt),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .branch_taken_i (branch_taken),
        .dmem_req_i     (dmem_req),
        .dcache_hit_i   (dcache_hit),
        .mem_ack_i      (mem_ack),
        .mem_req_o      (mem_req),
        .dcache_fill_o  (dcache_fill),
        .pc_we_o        (pc_we),
        .ifid_en_o      (ifid_en),
        .idex_en_o      (idex_en),
        .exmem_en_o     (exmem_en),
        .memwb_en_o     (memwb_en),
        .ifid_flush_o   (ifid_flush),
        .idex_flush_o   (idex_flush),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles_o (stall_cycles),
        .miss_count_o   (miss_count),
`endif
        .memwb_flush_o  (memwb_flush)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: refill request outstanding / refill write pending.
    bit m_waiting = 1'b0;
    bit m_filling = 1'b0;
    int m_stalls  = 0;
    int m_misses  = 0;

    int seen_pc_low  = 0;
    int seen_req_hi  = 0;
    int seen_fill_hi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (posedge+1); sample at posedge+4, then advance.
    task automatic cycle();
        logic [4:0] exp_en;
        logic [2:0] exp_fl;
        bit lu, miss;
        #3;
        lu   = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        miss = m_waiting || m_filling || (dmem_req && !dcache_hit);
        if (rst)               begin exp_en = 5'b00000; exp_fl = 3'b111; end
        else if (miss)         begin exp_en = 5'b00001; exp_fl = 3'b001; end
        else if (lu)           begin exp_en = 5'b00111; exp_fl = 3'b010; end
        else if (branch_taken) begin exp_en = 5'b11111; exp_fl = 3'b100; end
        else                   begin exp_en = 5'b11111; exp_fl = 3'b000; end

        check("enables", {27'd0, pc_we, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, exp_en});
        check("flushes", {29'd0, ifid_flush, idex_flush, memwb_flush}, {29'd0, exp_fl});
        check("mem_req", {31'd0, mem_req}, {31'd0, m_waiting});
        check("dcache_fill", {31'd0, dcache_fill}, {31'd0, m_filling});
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cycles", {{(32-CNT_W){1'b0}}, stall_cycles}, m_stalls);
        check("miss_count", {{(32-CNT_W){1'b0}}, miss_count}, m_misses);
`endif
        if (!pc_we) seen_pc_low++;
        if (mem_req) seen_req_hi++;
        if (dcache_fill) seen_fill_hi++;

        if (rst) begin
            m_waiting = 0; m_filling = 0; m_stalls = 0; m_misses = 0;
        end else begin
            if (!exp_en[4] && m_stalls < CNT_MAX) m_stalls++;
            if (m_filling) m_filling = 0;
            else if (m_waiting) begin
                if (mem_ack) begin m_waiting = 0; m_filling = 1; end
            end else if (dmem_req && !dcache_hit) begin
                m_waiting = 1;
                if (m_misses < CNT_MAX) m_misses++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; dmem_req = 0; dcache_hit = 1; mem_ack = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        cycle();

        // Load-use with hitting cache, then release
        idex_memread = 1; idex_rt = 5; ifid_rs = 5; dmem_req = 1; dcache_hit = 1;
        cycle();
        idle_inputs();
        cycle();
        // Load into r0 never stalls
        idex_memread = 1; idex_rt = 0; ifid_rs = 0;
        cycle();
        idle_inputs();
        // Taken branch alone, then branch plus load-use
        branch_taken = 1;
        cycle();
        idex_memread = 1; idex_rt = 7; ifid_rt = 7;
        cycle();
        idle_inputs();
        cycle();
        // Stray ack in RUN
        mem_ack = 1;
        cycle();
        mem_ack = 0;
        cycle();

        // Miss with ack after three request cycles
        rst = 1;
        cycle();
        rst = 0;
        seen_pc_low = 0; seen_req_hi = 0; seen_fill_hi = 0;
        dmem_req = 1; dcache_hit = 0;
        cycle();
        cycle();
        cycle();
        mem_ack = 1;
        cycle();
        mem_ack = 0;
        cycle();
        dcache_hit = 1;
        cycle();
        check("miss_pc_we_low_cycles", seen_pc_low, 5);
        check("miss_req_cycles", seen_req_hi, 3);
        check("miss_fill_cycles", seen_fill_hi, 1);
`ifdef PIPE_CTRL_PERF_EN
        check("miss_stall_total", {{(32-CNT_W){1'b0}}, stall_cycles}, 5);
        check("miss_count_total", {{(32-CNT_W){1'b0}}, miss_count}, 1);
`endif
        idle_inputs();

        // Ack coinciding with miss detection is ignored
        dmem_req = 1; dcache_hit = 0; mem_ack = 1;
        cycle();
        mem_ack = 0;
        cycle();
        cycle();
        mem_ack = 1;
        cycle();
        mem_ack = 0;
        cycle();
        dcache_hit = 1;
        cycle();
        idle_inputs();

        // Reset while in MISS
        dmem_req = 1; dcache_hit = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        idle_inputs();
        cycle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            idex_memread = ($urandom_range(0, 1) == 1);
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 3) == 0);
            dmem_req     = ($urandom_range(0, 1) == 1);
            dcache_hit   = ($urandom_range(0, 3) != 0);
            mem_ack      = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
